// File: rtl/mc_state_regs_if.sv
// Control strobes, datapath inputs and registered state outputs of the
// multi-cycle MIPS state-register stage.
interface mc_state_regs_if;
  logic        IorD;
  logic [1:0]  PCSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        Branch;
  logic [31:0] ALUResult;
  logic        Zero;
  logic [31:0] ReadData;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] PC;
  logic [31:0] Adr;
  logic [31:0] Instr;
  logic [31:0] Data;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUOut;
  logic        PCEn;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [31:0] SignImm;
  logic [31:0] InstrCount;

  modport master (
    output IorD, PCSrc, IRWrite, PCWrite, Branch,
    output ALUResult, Zero, ReadData, RD1, RD2,
    input  PC, Adr, Instr, Data, A, B, ALUOut, PCEn,
    input  Opcode, Funct, Rs, Rt, Rd, SignImm, InstrCount
  );

  modport slave (
    input  IorD, PCSrc, IRWrite, PCWrite, Branch,
    input  ALUResult, Zero, ReadData, RD1, RD2,
    output PC, Adr, Instr, Data, A, B, ALUOut, PCEn,
    output Opcode, Funct, Rs, Rt, Rd, SignImm, InstrCount
  );
endinterface

// File: rtl/mc_state_regs.sv
// Multi-cycle MIPS non-architectural state registers: PC, IR, MDR,
// A/B, ALUOut, memory address mux, field decode and fetch counter.
module mc_state_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  mc_state_regs_if.slave  bus
);

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_data;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_aluout;
  logic [31:0] r_instr_count;
  logic        w_pcen;
  logic [31:0] w_pc_next;

  assign w_pcen = bus.PCWrite | (bus.Branch & bus.Zero);

  // Jump target keeps the region bits of the already-incremented PC
  always_comb begin
    w_pc_next = r_pc;
    case (bus.PCSrc)
      2'b00:   w_pc_next = bus.ALUResult;
      2'b01:   w_pc_next = r_aluout;
      2'b10:   w_pc_next = {r_pc[31:28], r_instr[25:0], 2'b00};
      default: w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_data        <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_aluout      <= '0;
      r_instr_count <= '0;
    end else begin
      if (w_pcen)
        r_pc <= w_pc_next;
      if (bus.IRWrite) begin
        r_instr       <= bus.ReadData;
        r_instr_count <= r_instr_count + 32'd1;
      end
      r_data   <= bus.ReadData;
      r_a      <= bus.RD1;
      r_b      <= bus.RD2;
      r_aluout <= bus.ALUResult;
    end
  end

  assign bus.PC         = r_pc;
  assign bus.Adr        = bus.IorD ? r_aluout : r_pc;
  assign bus.Instr      = r_instr;
  assign bus.Data       = r_data;
  assign bus.A          = r_a;
  assign bus.B          = r_b;
  assign bus.ALUOut     = r_aluout;
  assign bus.PCEn       = w_pcen;
  assign bus.Opcode     = r_instr[31:26];
  assign bus.Funct      = r_instr[5:0];
  assign bus.Rs         = r_instr[25:21];
  assign bus.Rt         = r_instr[20:16];
  assign bus.Rd         = r_instr[15:11];
  assign bus.SignImm    = {{16{r_instr[15]}}, r_instr[15:0]};
  assign bus.InstrCount = r_instr_count;

endmodule

// File: tb/tb_mc_state_regs.sv
// Scoreboard bench for mc_state_regs: expected values are queued when
// stimulus is driven and popped once the DUT output is sampled.
module tb_mc_state_regs;

  localparam int O_PC    = 0;
  localparam int O_ADR   = 1;
  localparam int O_INSTR = 2;
  localparam int O_DATA  = 3;
  localparam int O_A     = 4;
  localparam int O_B     = 5;
  localparam int O_ALUO  = 6;
  localparam int O_PCEN  = 7;
  localparam int O_OPC   = 8;
  localparam int O_FUNCT = 9;
  localparam int O_RS    = 10;
  localparam int O_RT    = 11;
  localparam int O_RD    = 12;
  localparam int O_SIMM  = 13;
  localparam int O_CNT   = 14;

  typedef struct {
    string       name;
    int          id;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  mc_state_regs_if bus ();

  mc_state_regs #(.RESET_PC(32'h0000_0040)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input int id);
    case (id)
      O_PC:    return bus.PC;
      O_ADR:   return bus.Adr;
      O_INSTR: return bus.Instr;
      O_DATA:  return bus.Data;
      O_A:     return bus.A;
      O_B:     return bus.B;
      O_ALUO:  return bus.ALUOut;
      O_PCEN:  return {31'd0, bus.PCEn};
      O_OPC:   return {26'd0, bus.Opcode};
      O_FUNCT: return {26'd0, bus.Funct};
      O_RS:    return {27'd0, bus.Rs};
      O_RT:    return {27'd0, bus.Rt};
      O_RD:    return {27'd0, bus.Rd};
      O_SIMM:  return bus.SignImm;
      O_CNT:   return bus.InstrCount;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  function automatic void push(input string n, input int id,
                               input logic [31:0] e);
    exp_t t;
    t.name = n;
    t.id   = id;
    t.exp  = e;
    sb.push_back(t);
  endfunction

  task automatic idle();
    bus.IorD      = 1'b0;
    bus.PCSrc     = 2'b00;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.Branch    = 1'b0;
    bus.Zero      = 1'b0;
    bus.ALUResult = '0;
    bus.ReadData  = '0;
    bus.RD1       = '0;
    bus.RD2       = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    idle();
    bus.ReadData  = 32'h1234_5678;
    bus.ALUResult = 32'h0000_0099;
    bus.IRWrite   = 1'b1;
    bus.PCWrite   = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    push("rst_pc", O_PC, 32'h40);
    push("rst_adr", O_ADR, 32'h40);
    push("rst_instr", O_INSTR, 32'h0);
    push("rst_cnt", O_CNT, 32'h0);
    push("rst_aluout", O_ALUO, 32'h0);
    push("rst_opcode", O_OPC, 32'h0);
    push("rst_simm", O_SIMM, 32'h0);
    push("rst_pcen", O_PCEN, 32'h1);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.id) !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.id), e.exp);
      end
    end
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    exp_t e;
    @(negedge clk);
    bus.ReadData  = 32'h2008_0005;
    bus.ALUResult = 32'h0000_0044;
    bus.IRWrite   = 1'b1;
    bus.PCWrite   = 1'b1;
    bus.PCSrc     = 2'b00;
    bus.IorD      = 1'b0;
    #1;
    checks++;
    if (bus.Adr !== 32'h40) begin
      failures++;
      $display("FAIL fetch_adr_old: got %h expected %h", bus.Adr, 32'h40);
    end
    push("fetch_pc", O_PC, 32'h44);
    push("fetch_instr", O_INSTR, 32'h2008_0005);
    push("fetch_opcode", O_OPC, 32'h08);
    push("fetch_rt", O_RT, 32'h08);
    push("fetch_rs", O_RS, 32'h00);
    push("fetch_simm", O_SIMM, 32'h5);
    push("fetch_cnt", O_CNT, 32'h1);
    push("fetch_data", O_DATA, 32'h2008_0005);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.id) !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.id), e.exp);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    @(negedge clk);
    idle();
    bus.ALUResult = 32'h0000_0080;
    bus.RD1       = 32'h0000_0011;
    bus.RD2       = 32'h0000_0022;
    push("br_aluout", O_ALUO, 32'h80);
    push("br_a", O_A, 32'h11);
    push("br_b", O_B, 32'h22);
    push("br_pc_idle", O_PC, 32'h44);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.id) !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.id), e.exp);
      end
    end
    @(negedge clk);
    bus.Branch    = 1'b1;
    bus.PCSrc     = 2'b01;
    bus.Zero      = 1'b0;
    bus.ALUResult = 32'h0000_0005;
    #1;
    checks++;
    if (bus.PCEn !== 1'b0) begin
      failures++;
      $display("FAIL br_pcen_z0: got %b expected 0", bus.PCEn);
    end
    push("br_nt_pc", O_PC, 32'h44);
    push("br_nt_aluout", O_ALUO, 32'h5);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.id) !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.id), e.exp);
      end
    end
    @(negedge clk);
    bus.Branch    = 1'b0;
    bus.ALUResult = 32'h0000_0080;
    @(negedge clk);
    bus.Branch    = 1'b1;
    bus.Zero      = 1'b1;
    bus.PCSrc     = 2'b01;
    bus.ALUResult = 32'h0000_0000;
    #1;
    checks++;
    if (bus.PCEn !== 1'b1) begin
      failures++;
      $display("FAIL br_pcen_z1: got %b expected 1", bus.PCEn);
    end
    push("br_t_pc", O_PC, 32'h80);
    push("br_t_aluout", O_ALUO, 32'h0);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.id) !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.id), e.exp);
      end
    end
    @(negedge clk);
    bus.PCWrite   = 1'b1;
    bus.Branch    = 1'b1;
    bus.Zero      = 1'b0;
    bus.PCSrc     = 2'b00;
    bus.ALUResult = 32'h0000_0090;
    push("br_pcw_pc", O_PC, 32'h90);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.id) !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.id), e.exp);
      end
    end
  endtask

  task automatic test_jump();
    exp_t e;
    @(negedge clk);
    idle();
    bus.ReadData  = 32'h0800_0010;
    bus.ALUResult = 32'h1000_0004;
    bus.IRWrite   = 1'b1;
    bus.PCWrite   = 1'b1;
    push("j_fetch_pc", O_PC, 32'h1000_0004);
    push("j_fetch_opc", O_OPC, 32'h02);
    push("j_fetch_cnt", O_CNT, 32'h2);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.id) !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.id), e.exp);
      end
    end
    @(negedge clk);
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b1;
    bus.PCSrc     = 2'b10;
    bus.ALUResult = 32'h0000_DEAD;
    push("j_pc", O_PC, 32'h1000_0040);
    push("j_instr_hold", O_INSTR, 32'h0800_0010);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.id) !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.id), e.exp);
      end
    end
  endtask

  task automatic test_addr_imm();
    exp_t e;
    @(negedge clk);
    idle();
    bus.ReadData  = 32'h2108_FFFC;
    bus.ALUResult = 32'h0000_0200;
    bus.IRWrite   = 1'b1;
    push("ai_pc_hold", O_PC, 32'h1000_0040);
    push("ai_aluout", O_ALUO, 32'h200);
    push("ai_adr_pc", O_ADR, 32'h1000_0040);
    push("ai_simm", O_SIMM, 32'hFFFF_FFFC);
    push("ai_opc", O_OPC, 32'h08);
    push("ai_rs", O_RS, 32'h08);
    push("ai_rt", O_RT, 32'h08);
    push("ai_rd", O_RD, 32'h1F);
    push("ai_funct", O_FUNCT, 32'h3C);
    push("ai_cnt", O_CNT, 32'h3);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.id) !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.id), e.exp);
      end
    end
    @(negedge clk);
    bus.IRWrite   = 1'b0;
    bus.IorD      = 1'b1;
    #1;
    checks++;
    if (bus.Adr !== 32'h200) begin
      failures++;
      $display("FAIL ai_adr_alu: got %h expected %h", bus.Adr, 32'h200);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold_wrap();
    exp_t e;
    @(negedge clk);
    idle();
    bus.PCWrite   = 1'b1;
    bus.PCSrc     = 2'b11;
    bus.ALUResult = 32'h0000_1234;
    bus.ReadData  = 32'h0000_AAAA;
    push("hw_pc_hold", O_PC, 32'h1000_0040);
    push("hw_instr_hold", O_INSTR, 32'h2108_FFFC);
    push("hw_data", O_DATA, 32'h0000_AAAA);
    push("hw_cnt_hold", O_CNT, 32'h3);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.id) !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.id), e.exp);
      end
    end
    @(negedge clk);
    idle();
    force dut.r_instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_instr_count;
    bus.IRWrite  = 1'b1;
    bus.ReadData = 32'h0000_0BAD;
    push("hw_cnt_wrap", O_CNT, 32'h0);
    push("hw_instr_load", O_INSTR, 32'h0000_0BAD);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.id) !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, obs(e.id), e.exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_fetch();
    test_branch();
    test_jump();
    test_addr_imm();
    test_hold_wrap();
    @(negedge clk);
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
